// File: rtl/spi_rx_pkg.sv
// Shared types and frame field positions for the SPI frame receiver.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic COPI_IDLE = 1'b0;
  localparam logic NCS_IDLE  = 1'b1;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage pin synchroniser; resets every stage to the pin's idle level.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= {STAGES{RST_VAL}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronises the pins, deserialises 16-bit frames
// and emits validated write strobes.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for nCS to fall
// ST_SHIFT | nCS low, shifting COPI on each SCLK rise
// ST_CHECK | nCS released, one-cycle decision: valid, error or drop
module spi_frame_rx
  import spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int MAX_ADDR    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_i,
  input  logic              copi_i,
  input  logic              ncs_i,
  output logic              frame_valid,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_err,
  output logic [7:0]        frame_count,
  output logic              busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);

  logic sclk_s, copi_s, ncs_s;
  logic sclk_d, ncs_d;
  logic sclk_rise_q, ncs_rise_q, ncs_fall_q;
  logic fall_pend;
  state_t state;
  logic [FRAME_BITS-1:0] sr;
  logic [CNT_W-1:0] cnt;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk_i), .q(sclk_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(COPI_IDLE)) u_sync_copi (
    .clk(clk), .rst(rst), .d(copi_i), .q(copi_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(NCS_IDLE)) u_sync_ncs (
    .clk(clk), .rst(rst), .d(ncs_i), .q(ncs_s));

  // Edge pulses are registered; COPI is stable well past a synced SCLK rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_d      <= SCLK_IDLE;
      ncs_d       <= NCS_IDLE;
      sclk_rise_q <= 1'b0;
      ncs_rise_q  <= 1'b0;
      ncs_fall_q  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sclk_d      <= sclk_s;
      ncs_d       <= ncs_s;
      sclk_rise_q <= sclk_s & ~sclk_d;
      ncs_rise_q  <= ncs_s & ~ncs_d;
      ncs_fall_q  <= ~ncs_s & ncs_d;
      busy        <= ~ncs_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      sr          <= '0;
      cnt         <= '0;
      fall_pend   <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_addr  <= '0;
      frame_data  <= '0;
      frame_count <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ncs_fall_q || fall_pend) begin
            state     <= ST_SHIFT;
            sr        <= '0;
            cnt       <= '0;
            fall_pend <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (ncs_rise_q) begin
            state <= ST_CHECK;
          end else if (sclk_rise_q) begin
            sr <= {sr[FRAME_BITS-2:0], copi_s};
            if (cnt != CNT_W'(FRAME_BITS + 1)) cnt <= cnt + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          // A new frame starting right away must not be lost while deciding.
          if (ncs_fall_q) fall_pend <= 1'b1;
          if (cnt != CNT_W'(FRAME_BITS)) begin
            frame_err <= 1'b1;
          end else if (sr[RW_BIT]) begin
            if (sr[ADDR_MSB:ADDR_LSB] > ADDR_W'(MAX_ADDR)) begin
              frame_err <= 1'b1;
            end else begin
              frame_valid <= 1'b1;
              frame_addr  <= sr[ADDR_MSB:ADDR_LSB];
              frame_data  <= sr[DATA_MSB:0];
              frame_count <= frame_count + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed self-checking bench for spi_frame_rx.
module tb_spi_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk_i = 1'b0;
  logic       copi_i = 1'b0;
  logic       ncs_i = 1'b1;
  logic       frame_valid;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       frame_err;
  logic [7:0] frame_count;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;

  localparam int HALF = 4;

  spi_frame_rx dut (
    .clk(clk), .rst(rst), .sclk_i(sclk_i), .copi_i(copi_i), .ncs_i(ncs_i),
    .frame_valid(frame_valid), .frame_addr(frame_addr), .frame_data(frame_data),
    .frame_err(frame_err), .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) n_valid++;
      if (frame_err)   n_err++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start();
    ncs_i = 1'b0;
    wait_clk(HALF);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_frame: got %b expected 1", busy);
    end
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi_i = bits[i];
      wait_clk(HALF);
      sclk_i = 1'b1;
      wait_clk(HALF);
      sclk_i = 1'b0;
    end
  endtask

  // Returns the strobe latency in cycles counted from the first edge sampling nCS high.
  task automatic frame_end(output int lat);
    lat = -1;
    wait_clk(HALF);
    ncs_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && (frame_valid || frame_err)) lat = k;
    end
    wait_clk(2);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_frame: got %b expected 0", busy);
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n, output int lat);
    frame_start();
    shift_bits(bits, n);
    frame_end(lat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sclk_i = 1'b0;
    copi_i = 1'b0;
    ncs_i = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(3);
    n_checks++;
    if ({frame_valid, frame_err, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 000", {frame_valid, frame_err, busy});
    end
    n_checks++;
    if ({frame_addr, frame_data, frame_count} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got addr=%h data=%h cnt=%0d expected 0", frame_addr, frame_data, frame_count);
    end
    rst = 1'b0;
    wait_clk(3);
  endtask

  task automatic test_write();
    int v0, e0, lat;
    v0 = n_valid; e0 = n_err;
    send_frame(32'h81A5, 16, lat);
    n_checks++;
    if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
      n_fail++;
      $display("FAIL write_strobes: got valid=%0d err=%0d expected 1 0", n_valid - v0, n_err - e0);
    end
    n_checks++;
    if (frame_addr !== 7'h01 || frame_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_fields: got %h/%h expected 01/a5", frame_addr, frame_data);
    end
    n_checks++;
    if (frame_count !== 8'd1) begin
      n_fail++;
      $display("FAIL write_count: got %0d expected 1", frame_count);
    end
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL write_latency: got %0d expected 4", lat);
    end
  endtask

  task automatic test_bad_length();
    int v0, e0, lat15, lat17;
    v0 = n_valid; e0 = n_err;
    send_frame(32'h40D2, 15, lat15);
    send_frame(32'h103A5, 17, lat17);
    n_checks++;
    if (n_err - e0 !== 2 || n_valid - v0 !== 0) begin
      n_fail++;
      $display("FAIL bad_length_strobes: got err=%0d valid=%0d expected 2 0", n_err - e0, n_valid - v0);
    end
    n_checks++;
    if (lat15 !== 4 || lat17 !== 4) begin
      n_fail++;
      $display("FAIL bad_length_latency: got %0d %0d expected 4 4", lat15, lat17);
    end
    n_checks++;
    if (frame_count !== 8'd1) begin
      n_fail++;
      $display("FAIL bad_length_count: got %0d expected 1", frame_count);
    end
  endtask

  task automatic test_read();
    int v0, e0, lat;
    v0 = n_valid; e0 = n_err;
    send_frame(32'h02FF, 16, lat);
    n_checks++;
    if (n_valid - v0 !== 0 || n_err - e0 !== 0 || lat !== -1) begin
      n_fail++;
      $display("FAIL read_strobes: got valid=%0d err=%0d lat=%0d expected 0 0 -1", n_valid - v0, n_err - e0, lat);
    end
    n_checks++;
    if (frame_addr !== 7'h01 || frame_data !== 8'hA5 || frame_count !== 8'd1) begin
      n_fail++;
      $display("FAIL read_hold: got %h/%h cnt=%0d expected 01/a5 cnt=1", frame_addr, frame_data, frame_count);
    end
  endtask

  task automatic test_addr_range();
    int v0, e0, lat;
    v0 = n_valid; e0 = n_err;
    send_frame(32'h8511, 16, lat);
    n_checks++;
    if (n_err - e0 !== 1 || n_valid - v0 !== 0 || frame_addr !== 7'h01) begin
      n_fail++;
      $display("FAIL addr5_err: got err=%0d valid=%0d addr=%h expected 1 0 01", n_err - e0, n_valid - v0, frame_addr);
    end
    v0 = n_valid; e0 = n_err;
    send_frame(32'h843C, 16, lat);
    n_checks++;
    if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
      n_fail++;
      $display("FAIL addr4_strobes: got valid=%0d err=%0d expected 1 0", n_valid - v0, n_err - e0);
    end
    n_checks++;
    if (frame_addr !== 7'h04 || frame_data !== 8'h3C || frame_count !== 8'd2) begin
      n_fail++;
      $display("FAIL addr4_fields: got %h/%h cnt=%0d expected 04/3c cnt=2", frame_addr, frame_data, frame_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0, lat;
    v0 = n_valid; e0 = n_err;
    frame_start();
    shift_bits(32'h82, 8);
    do_reset();
    n_checks++;
    if (frame_count !== 8'd0 || frame_addr !== 7'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_clear: got cnt=%0d addr=%h busy=%b expected 0 00 0", frame_count, frame_addr, busy);
    end
    send_frame(32'h8280, 16, lat);
    n_checks++;
    if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
      n_fail++;
      $display("FAIL midreset_strobes: got valid=%0d err=%0d expected 1 0", n_valid - v0, n_err - e0);
    end
    n_checks++;
    if (frame_addr !== 7'h02 || frame_data !== 8'h80 || frame_count !== 8'd1) begin
      n_fail++;
      $display("FAIL midreset_fields: got %h/%h cnt=%0d expected 02/80 cnt=1", frame_addr, frame_data, frame_count);
    end
  endtask

  task automatic test_idle_toggle_and_wrap();
    int v0, e0, lat;
    do_reset();
    v0 = n_valid; e0 = n_err;
    for (int i = 0; i < 20; i++) begin
      sclk_i = 1'b1;
      copi_i = i[0];
      wait_clk(HALF);
      sclk_i = 1'b0;
      wait_clk(HALF);
    end
    wait_clk(10);
    n_checks++;
    if (n_valid - v0 !== 0 || n_err - e0 !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_toggle: got valid=%0d err=%0d busy=%b expected 0 0 0", n_valid - v0, n_err - e0, busy);
    end
    for (int i = 0; i < 255; i++) send_frame(32'h8000 | 32'(i % 5) << 8 | 32'(i), 16, lat);
    n_checks++;
    if (frame_count !== 8'd255 || frame_addr !== 7'd4 || frame_data !== 8'hFE) begin
      n_fail++;
      $display("FAIL count_255: got cnt=%0d %h/%h expected 255 04/fe", frame_count, frame_addr, frame_data);
    end
    send_frame(32'h8377, 16, lat);
    n_checks++;
    if (frame_count !== 8'd0 || n_valid - v0 !== 256 || n_err - e0 !== 0) begin
      n_fail++;
      $display("FAIL count_wrap: got cnt=%0d valid=%0d err=%0d expected 0 256 0", frame_count, n_valid - v0, n_err - e0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bad_length();
    test_read();
    test_addr_range();
    test_reset_mid_frame();
    test_idle_toggle_and_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
